// File: rtl/fpu_pkg.sv
// Shared FP32 types, constants and helpers for the FPU datapath blocks.
package fpu_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [31:0] FP32_CANON_QNAN = 32'h7FC00000;
  localparam logic [7:0]  FP32_EXP_MAX    = 8'hFF;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic logic is_nan(input fp32_t x);
    return (x.exp == FP32_EXP_MAX) && (x.man != 23'd0);
  endfunction

endpackage

// File: rtl/fp32_lt.sv
// Combinational FP32 sign-magnitude less-than; +0 and -0 compare equal.
module fp32_lt
  import fpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        lt
);

  fp32_t fa;
  fp32_t fb;
  logic [30:0] mag_a;
  logic [30:0] mag_b;

  assign fa    = a;
  assign fb    = b;
  assign mag_a = {fa.exp, fa.man};
  assign mag_b = {fb.exp, fb.man};

  always_comb begin
    lt = 1'b0;
    if ((mag_a == 31'd0) && (mag_b == 31'd0)) begin
      lt = 1'b0;
    end else if (fa.sign != fb.sign) begin
      lt = fa.sign;
    end else if (!fa.sign) begin
      lt = (mag_a < mag_b);
    end else begin
      lt = (mag_a > mag_b);
    end
  end

endmodule

// File: rtl/fmin_reduce.sv
// Streaming FP32 min/argmin reducer over a valid/ready packet stream.
// Define FMIN_REDUCE_NAN_EN for IEEE minNum NaN handling (NaNs lose to numbers).
module fmin_reduce
  import fpu_pkg::*;
#(
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic [IDX_W-1:0] m_index,
  output logic [IDX_W-1:0] m_count,
  output logic             m_overflow
);

  localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};

  state_t           state_q, state_d;
  logic [31:0]      cur_q, cur_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0] pos_q, pos_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             first_q, first_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;
  logic [IDX_W-1:0] res_cnt_q, res_cnt_d;
  logic             res_ovf_q, res_ovf_d;
`ifdef FMIN_REDUCE_NAN_EN
  logic             cur_is_nan_q, cur_is_nan_d;
  logic             win_is_nan;
`endif

  logic             beat;
  logic             beat_lt;
  logic             take;
  logic [31:0]      win_data;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] pos_inc;

  fp32_lt u_lt (
    .a  (s_data),
    .b  (cur_q),
    .lt (beat_lt)
  );

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    cur_idx_d = cur_idx_q;
    pos_d     = pos_q;
    full_d    = full_q;
    ovf_d     = ovf_q;
    first_d   = first_q;
    res_data_d = res_data_q;
    res_idx_d  = res_idx_q;
    res_cnt_d  = res_cnt_q;
    res_ovf_d  = res_ovf_q;

    beat = (state_q == ACCUM) && s_valid;
`ifdef FMIN_REDUCE_NAN_EN
    cur_is_nan_d = cur_is_nan_q;
    if (first_q) begin
      take = 1'b1;
    end else if (is_nan(fp32_t'(s_data))) begin
      take = 1'b0;
    end else if (cur_is_nan_q) begin
      take = 1'b1;
    end else begin
      take = beat_lt;
    end
    win_is_nan = take ? is_nan(fp32_t'(s_data)) : cur_is_nan_q;
`else
    take = first_q || beat_lt;
`endif
    win_data = take ? s_data : cur_q;
    win_idx  = take ? pos_q : cur_idx_q;
    // pos_q doubles as the saturating beat count
    pos_inc  = (pos_q == IDX_MAX) ? pos_q : pos_q + 1'b1;

    case (state_q)
      ACCUM: begin
        if (beat) begin
          cur_d     = win_data;
          cur_idx_d = win_idx;
          pos_d     = pos_inc;
          full_d    = full_q | (pos_q == IDX_MAX);
          ovf_d     = ovf_q | full_q;
          first_d   = 1'b0;
`ifdef FMIN_REDUCE_NAN_EN
          cur_is_nan_d = win_is_nan;
`endif
          if (s_last) begin
            res_data_d = win_data;
            res_idx_d  = win_idx;
            res_cnt_d  = pos_inc;
            res_ovf_d  = ovf_q | full_q;
`ifdef FMIN_REDUCE_NAN_EN
            if (win_is_nan) begin
              res_data_d = FP32_CANON_QNAN;
              res_idx_d  = '0;
            end
`endif
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (m_ready) begin
          state_d   = ACCUM;
          cur_d     = '0;
          cur_idx_d = '0;
          pos_d     = '0;
          full_d    = 1'b0;
          ovf_d     = 1'b0;
          first_d   = 1'b1;
`ifdef FMIN_REDUCE_NAN_EN
          cur_is_nan_d = 1'b0;
`endif
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACCUM;
      cur_q      <= '0;
      cur_idx_q  <= '0;
      pos_q      <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      first_q    <= 1'b1;
      res_data_q <= '0;
      res_idx_q  <= '0;
      res_cnt_q  <= '0;
      res_ovf_q  <= 1'b0;
`ifdef FMIN_REDUCE_NAN_EN
      cur_is_nan_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      cur_idx_q  <= cur_idx_d;
      pos_q      <= pos_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      first_q    <= first_d;
      res_data_q <= res_data_d;
      res_idx_q  <= res_idx_d;
      res_cnt_q  <= res_cnt_d;
      res_ovf_q  <= res_ovf_d;
`ifdef FMIN_REDUCE_NAN_EN
      cur_is_nan_q <= cur_is_nan_d;
`endif
    end
  end

  assign s_ready    = (state_q == ACCUM);
  assign m_valid    = (state_q == HOLD);
  assign m_data     = res_data_q;
  assign m_index    = res_idx_q;
  assign m_count    = res_cnt_q;
  assign m_overflow = res_ovf_q;

endmodule
